// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer:
// states, opcode classes, writeback selects and the default memory timeout.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1010;
    localparam logic [3:0] OP_JMP   = 4'b1011;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    localparam int DEF_WAIT_MAX = 15;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'b0001) && (op <= 4'b0111);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'b1100) && (op <= 4'b1110);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles; timeout flags the last
// tolerable cycle so the sequencer can divert to ERR on the next edge.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CW       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    logic [CW-1:0] r_cnt;

    // Clear wins over count; the counter parks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {CW{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_timeout = (r_cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: walks the datapath through fetch, decode, execute,
// memory and writeback, emitting per-cycle strobes straight from the state.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = DEF_WAIT_MAX,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       alu_en,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal_op,
    output logic       halted,
    output logic       bus_err,
    output logic [2:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_op_q;
    logic       w_timeout;
    logic       w_tmr_clr;
    logic       w_tmr_en;
    logic       w_in_memwait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_op_q <= OP_NOP;
        else if (r_state == S_DECODE)
            r_op_q <= opcode;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DECODE: begin
                if (opcode == OP_NOP || is_illegal_op(opcode)) w_next = S_FETCH;
                else if (opcode == OP_HLT)                     w_next = S_HALT;
                else                                           w_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu_op(r_op_q))                             w_next = S_WB;
                else if (r_op_q == OP_LOAD || r_op_q == OP_STORE)  w_next = S_MEM;
                else                                               w_next = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready)      w_next = (r_op_q == OP_LOAD) ? S_WB : S_FETCH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   if (start) w_next = S_FETCH;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_en     = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            // The IR holds the new instruction during DECODE, before op_q captures it.
            S_DECODE: illegal_op = is_illegal_op(opcode);
            S_EXEC: begin
                alu_en = 1'b1;
                if (r_op_q == OP_JMP)      pc_load = 1'b1;
                else if (r_op_q == OP_BEQ) pc_load = zero_flag;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_op_q == OP_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (r_op_q == OP_LOAD) ? WB_MEM : WB_ALU;
            end
            S_HALT:  halted  = 1'b1;
            S_ERR:   bus_err = 1'b1;
            default: ;
        endcase
    end

    assign w_in_memwait = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_tmr_en     = w_in_memwait && !mem_ready;
    assign w_tmr_clr    = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CW       (CW)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_timeout (w_timeout)
    );

    assign state = r_state;

endmodule
